// File: rtl/axi_lite_slave_regs.sv
// axi_lite_slave_regs
// AXI4-Lite responder exposing a four-word 32-bit register file.
// Registers 0-2 are read/write and drive fabric logic; register 3 returns the
// live status input. Write and read paths are independent and run concurrently.
//
// Optional feature macro: AXIL_SLV_WSTRB_EN adds a WSTRB[3:0] byte-enable input.
//
// Ports:
//   ACLK, ARESETn             clock, synchronous active-low reset
//   AWADDR/AWVALID/AWREADY    write address channel ([3:2] selects register)
//   WDATA/WVALID/WREADY       write data channel (+ WSTRB when enabled)
//   BRESP/BVALID/BREADY       write response channel (SLVERR for register 3)
//   ARADDR/ARVALID/ARREADY    read address channel ([3:2] selects register)
//   RDATA/RRESP/RVALID/RREADY read data channel (RRESP always OKAY)
//   status                    value returned on reads of register 3
//   reg0, reg1, reg2          current register contents
module axi_lite_slave_regs #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic [3:0]  AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
`ifdef AXIL_SLV_WSTRB_EN
    input  logic [3:0]  WSTRB,
`endif
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    input  logic [3:0]  ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY,
    input  logic [31:0] status,
    output logic [31:0] reg0,
    output logic [31:0] reg1,
    output logic [31:0] reg2
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;
    localparam logic [SEL_W-1:0] SEL_STATUS  = SEL_W'(3);

    typedef enum logic { AW_READY, AW_HELD } aw_state_t;
    typedef enum logic { W_READY,  W_HELD  } w_state_t;
    typedef enum logic { B_IDLE,   B_VALID } b_state_t;
    typedef enum logic { AR_READY, R_VALID } ar_state_t;

    aw_state_t aw_state, aw_state_nxt;
    w_state_t  w_state,  w_state_nxt;
    b_state_t  b_state,  b_state_nxt;
    ar_state_t ar_state, ar_state_nxt;

    logic aw_ready_nxt, w_ready_nxt, b_valid_nxt, ar_ready_nxt, r_valid_nxt;
    logic commit;

    logic [SEL_W-1:0]  aw_sel;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic [DATA_W-1:0] wr_old, wr_merged, rd_mux;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // Address low bits are byte offsets within a word and carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};

    assign aw_hs = AWVALID & AWREADY;
    assign w_hs  = WVALID  & WREADY;
    assign b_hs  = BVALID  & BREADY;
    assign ar_hs = ARVALID & ARREADY;
    assign r_hs  = RVALID  & RREADY;

    assign RRESP = RESP_OKAY;

    // State register; handshake outputs are flopped alongside the state.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            aw_state <= AW_READY;
            w_state  <= W_READY;
            b_state  <= B_IDLE;
            ar_state <= AR_READY;
            AWREADY  <= 1'b0;
            WREADY   <= 1'b0;
            BVALID   <= 1'b0;
            ARREADY  <= 1'b0;
            RVALID   <= 1'b0;
        end else begin
            aw_state <= aw_state_nxt;
            w_state  <= w_state_nxt;
            b_state  <= b_state_nxt;
            ar_state <= ar_state_nxt;
            AWREADY  <= aw_ready_nxt;
            WREADY   <= w_ready_nxt;
            BVALID   <= b_valid_nxt;
            ARREADY  <= ar_ready_nxt;
            RVALID   <= r_valid_nxt;
        end
    end

    // Next-state logic; AW and W are released together by the B handshake.
    always_comb begin
        aw_state_nxt = aw_state;
        w_state_nxt  = w_state;
        b_state_nxt  = b_state;
        ar_state_nxt = ar_state;
        case (aw_state)
            AW_READY: if (aw_hs) aw_state_nxt = AW_HELD;
            AW_HELD:  if (b_hs)  aw_state_nxt = AW_READY;
            default:  aw_state_nxt = AW_READY;
        endcase
        case (w_state)
            W_READY: if (w_hs) w_state_nxt = W_HELD;
            W_HELD:  if (b_hs) w_state_nxt = W_READY;
            default: w_state_nxt = W_READY;
        endcase
        case (b_state)
            B_IDLE:  if (aw_state == AW_HELD && w_state == W_HELD) b_state_nxt = B_VALID;
            B_VALID: if (b_hs) b_state_nxt = B_IDLE;
            default: b_state_nxt = B_IDLE;
        endcase
        case (ar_state)
            AR_READY: if (ar_hs) ar_state_nxt = R_VALID;
            R_VALID:  if (r_hs)  ar_state_nxt = AR_READY;
            default:  ar_state_nxt = AR_READY;
        endcase
    end

    // Output decode from next state so the flopped outputs track the state.
    always_comb begin
        aw_ready_nxt = 1'b0;
        w_ready_nxt  = 1'b0;
        b_valid_nxt  = 1'b0;
        ar_ready_nxt = 1'b0;
        r_valid_nxt  = 1'b0;
        commit       = 1'b0;
        aw_ready_nxt = (aw_state_nxt == AW_READY);
        w_ready_nxt  = (w_state_nxt  == W_READY);
        b_valid_nxt  = (b_state_nxt  == B_VALID);
        ar_ready_nxt = (ar_state_nxt == AR_READY);
        r_valid_nxt  = (ar_state_nxt == R_VALID);
        commit       = (b_state == B_IDLE) && (b_state_nxt == B_VALID);
    end

    // Byte-merge of latched write data into the currently addressed register.
    always_comb begin
        wr_old = RESET_VAL;
        case (aw_sel)
            SEL_W'(0): wr_old = reg0;
            SEL_W'(1): wr_old = reg1;
            SEL_W'(2): wr_old = reg2;
            default:   wr_old = RESET_VAL;
        endcase
        wr_merged = wr_old;
        for (int k = 0; k < int'(STRB_W); k++) begin
            if (w_strb[k]) wr_merged[k*8 +: 8] = w_data[k*8 +: 8];
        end
    end

    // Read source select; register 3 is the live status input.
    always_comb begin
        rd_mux = status;
        case (ARADDR[3:2])
            SEL_W'(0): rd_mux = reg0;
            SEL_W'(1): rd_mux = reg1;
            SEL_W'(2): rd_mux = reg2;
            default:   rd_mux = status;
        endcase
    end

    // Write address/data capture, commit and response.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            aw_sel <= '0;
            w_data <= '0;
            w_strb <= '0;
            BRESP  <= RESP_OKAY;
            reg0   <= RESET_VAL;
            reg1   <= RESET_VAL;
            reg2   <= RESET_VAL;
        end else begin
            if (aw_hs) aw_sel <= AWADDR[3:2];
            if (w_hs) begin
                w_data <= WDATA;
`ifdef AXIL_SLV_WSTRB_EN
                w_strb <= WSTRB;
`else
                w_strb <= '1;
`endif
            end
            if (commit) begin
                BRESP <= (aw_sel == SEL_STATUS) ? RESP_SLVERR : RESP_OKAY;
                case (aw_sel)
                    SEL_W'(0): reg0 <= wr_merged;
                    SEL_W'(1): reg1 <= wr_merged;
                    SEL_W'(2): reg2 <= wr_merged;
                    default:   ;
                endcase
            end
        end
    end

    // Read data capture; samples pre-write register values on a shared edge.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            RDATA <= '0;
        end else if (ar_hs) begin
            RDATA <= rd_mux;
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Scoreboard bench for axi_lite_slave_regs: stimulus pushes expected B/R
// responses into queues, monitors pop and compare on each handshake.
module tb_axi_lite_slave_regs;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [3:0]  AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [3:0]  ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] status;
    logic [31:0] reg0, reg1, reg2;

    int checks   = 0;
    int failures = 0;

    logic [1:0]  b_q[$];
    logic [33:0] r_q[$];

    axi_lite_slave_regs dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA),
`ifdef AXIL_SLV_WSTRB_EN
        .WSTRB(WSTRB),
`endif
        .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .status(status), .reg0(reg0), .reg1(reg1), .reg2(reg2)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Same-cycle AW+W write with BREADY high: handshake, commit, B handshake.
    task automatic wr(input logic [3:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [1:0] resp);
        AWADDR = addr; WDATA = data; WSTRB = strb;
        AWVALID = 1'b1; WVALID = 1'b1;
        b_q.push_back(resp);
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        tick();
        tick();
    endtask

    task automatic rd(input logic [3:0] addr, input logic [31:0] exp);
        ARADDR = addr; ARVALID = 1'b1;
        r_q.push_back({2'b00, exp});
        tick();
        ARVALID = 1'b0;
        tick();
    endtask

    // Write response monitor.
    always @(negedge ACLK) begin
        if (ARESETn && BVALID && BREADY) begin
            if (b_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected: got BRESP %h with no response expected", BRESP);
            end else begin
                chk("bresp", 32'(BRESP), 32'(b_q.pop_front()));
            end
        end
    end

    // Read data monitor.
    always @(negedge ACLK) begin
        logic [33:0] e;
        if (ARESETn && RVALID && RREADY) begin
            if (r_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL r_unexpected: got RDATA %h with no read expected", RDATA);
            end else begin
                e = r_q.pop_front();
                chk("rdata", RDATA, e[31:0]);
                chk("rresp", 32'(RRESP), 32'(e[33:32]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETn = 1'b0; AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = 4'hF;
        WVALID = 1'b0; BREADY = 1'b1; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b1;
        status = 32'hA5A5_0001;

        // Reset held three cycles
        tick(); tick(); tick();
        chk("rst_reg0", reg0, 32'h0);
        chk("rst_reg1", reg1, 32'h0);
        chk("rst_reg2", reg2, 32'h0);
        chk("rst_hs", {27'h0, AWREADY, WREADY, ARREADY, BVALID, RVALID}, 32'h0);
        chk("rst_data", {BRESP, RRESP, 28'h0} | RDATA, 32'h0);
        ARESETn = 1'b1;
        #1;
        chk("rst_rel_ready", {29'h0, AWREADY, WREADY, ARREADY}, 32'h0);
        tick();
        chk("ready_after_rst", {29'h0, AWREADY, WREADY, ARREADY}, 32'h7);

        // AW first, W two cycles later
        AWADDR = 4'h4; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        chk("aw_held_ready", 32'(AWREADY), 32'h0);
        tick();
        WDATA = 32'hDEAD_BEEF; WVALID = 1'b1;
        b_q.push_back(2'b00);
        tick();
        WVALID = 1'b0;
        chk("w_held_ready", 32'(WREADY), 32'h0);
        chk("b_not_yet", 32'(BVALID), 32'h0);
        chk("reg1_not_yet", reg1, 32'h0);
        tick();
        chk("reg1_commit", reg1, 32'hDEAD_BEEF);
        chk("b_valid", 32'(BVALID), 32'h1);
        tick();
        chk("ready_after_b", {30'h0, AWREADY, WREADY}, 32'h3);
        chk("b_dropped", 32'(BVALID), 32'h0);

        // W first, AW later
        WDATA = 32'h5555_AAAA; WVALID = 1'b1;
        b_q.push_back(2'b00);
        tick();
        WVALID = 1'b0;
        tick();
        AWADDR = 4'h8; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        tick();
        chk("reg2_wfirst", reg2, 32'h5555_AAAA);
        tick();

        // Same-cycle AW+W with BREADY held low for five cycles
        BREADY = 1'b0;
        AWADDR = 4'h8; WDATA = 32'h1234_5678; AWVALID = 1'b1; WVALID = 1'b1;
        b_q.push_back(2'b00);
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        tick();
        chk("reg2_same", reg2, 32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            chk("b_hold_valid", 32'(BVALID), 32'h1);
            chk("b_hold_ready", {30'h0, AWREADY, WREADY}, 32'h0);
            tick();
        end
        BREADY = 1'b1;
        tick();
        chk("b_release", 32'(BVALID), 32'h0);
        tick();

        // Write to status register is rejected
        wr(4'hC, 32'hFFFF_FFFF, 4'hF, 2'b10);
        chk("slverr_reg0", reg0, 32'h0);
        chk("slverr_reg1", reg1, 32'hDEAD_BEEF);
        chk("slverr_reg2", reg2, 32'h1234_5678);
        rd(4'hC, 32'hA5A5_0001);
        rd(4'h4, 32'hDEAD_BEEF);

        // Read capture on the same edge as the write commit returns old data
        AWADDR = 4'h0; WDATA = 32'h0000_00FF; AWVALID = 1'b1; WVALID = 1'b1;
        b_q.push_back(2'b00);
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        ARADDR = 4'h0; ARVALID = 1'b1;
        r_q.push_back({2'b00, 32'h0});
        tick();
        ARVALID = 1'b0;
        chk("race_rdata", RDATA, 32'h0);
        chk("race_reg0", reg0, 32'h0000_00FF);
        tick();
        tick();

        // Read held with RREADY low
        RREADY = 1'b0;
        ARADDR = 4'h0; ARVALID = 1'b1;
        r_q.push_back({2'b00, 32'h0000_00FF});
        tick();
        ARVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("r_hold_data", RDATA, 32'h0000_00FF);
            chk("r_hold_hs", {30'h0, RVALID, ARREADY}, 32'h2);
            tick();
        end
        RREADY = 1'b1;
        tick();
        chk("r_release", 32'(RVALID), 32'h0);
        tick();
        chk("ar_ready_back", 32'(ARREADY), 32'h1);

`ifdef AXIL_SLV_WSTRB_EN
        wr(4'h0, 32'h1111_1111, 4'hF, 2'b00);
        wr(4'h0, 32'hAABB_CCDD, 4'b0101, 2'b00);
        chk("wstrb_merge", reg0, 32'h11BB_11DD);
        wr(4'h0, 32'h0000_0000, 4'b0000, 2'b00);
        chk("wstrb_none", reg0, 32'h11BB_11DD);
`endif

        // Reset in the middle of pending B and R responses
        BREADY = 1'b0; RREADY = 1'b0;
        AWADDR = 4'h4; WDATA = 32'h0BAD_0BAD; AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 4'h8; ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        tick();
        chk("mid_commit", reg1, 32'h0BAD_0BAD);
        ARESETn = 1'b0;
        tick();
        chk("mid_rst_valid", {30'h0, BVALID, RVALID}, 32'h0);
        chk("mid_rst_reg1", reg1, 32'h0);
        chk("mid_rst_reg0", reg0, 32'h0);
        ARESETn = 1'b1; BREADY = 1'b1; RREADY = 1'b1;
        tick();
        chk("mid_rst_ready", {29'h0, AWREADY, WREADY, ARREADY}, 32'h7);
        wr(4'h8, 32'hCAFE_0002, 4'hF, 2'b00);
        chk("post_rst_write", reg2, 32'hCAFE_0002);
        tick();

        chk("b_q_empty", 32'(b_q.size()), 32'h0);
        chk("r_q_empty", 32'(r_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_lite_slave_regs.md
# axi_lite_slave_regs

AXI4-Lite responder (slave) exposing a four-word 32-bit register file to an AXI-Lite initiator on the Basys3 design. It accepts write address/data in either order, commits the write, returns a B response, and serves reads with a registered R channel. Registers 0–2 are read/write and drive fabric logic; register 3 is a read-only status input. Read and write paths operate independently and concurrently.

## Interface
Parameters:
- RESET_VAL, 32'h0000_0000, reset value of registers 0–2

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESETn  in  1  reset, synchronous, active-low
- AWADDR  in  4  write address; bits [3:2] select register, [1:0] ignored
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- WDATA  in  32  write data
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- BRESP  out  2  write response
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- ARADDR  in  4  read address; bits [3:2] select register
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- RDATA  out  32  read data
- RRESP  out  2  read response, always 2'b00
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- status  in  32  value returned on reads of register 3
- reg0, reg1, reg2  out  32 each  current register contents

## Operation
- All handshake outputs are registered. During reset: AWREADY, WREADY, ARREADY, BVALID, RVALID = 0; BRESP, RRESP, RDATA = 0; reg0–reg2 = RESET_VAL.
- AW FSM: AW_READY (AWREADY=1) → AW_HELD on AWVALID&AWREADY, latch AWADDR[3:2]; AWREADY=0 in AW_HELD; return to AW_READY on B handshake.
- W FSM: W_READY (WREADY=1) → W_HELD on WVALID&WREADY, latch WDATA; WREADY=0 in W_HELD; return on B handshake.
- AW and W accepted in either order or same cycle; each is held off until B completes.
- B FSM: B_IDLE → B_VALID when AW_HELD and W_HELD; on that edge the write commits. BVALID=1 held until BREADY; on BVALID&BREADY → B_IDLE, AW/W return to READY.
- Address 0–2: register updated, BRESP=2'b00 (OKAY). Address 3: no state change, BRESP=2'b10 (SLVERR).
- AR FSM: AR_READY (ARREADY=1) → R_VALID on ARVALID&ARREADY; RDATA captured same edge from selected register (reg3 = status sampled that edge). In R_VALID: ARREADY=0, RVALID=1, RDATA stable until RVALID&RREADY → AR_READY.
- Read and write channels share no FSM state; simultaneous transactions proceed in parallel.

## Timing
- Readies assert on the first edge after ARESETn deasserts.
- Write: both AW and W handshaken by edge N → register and BVALID updated at edge N+1. Minimum write: 2 cycles to BVALID, 3 cycles until AWREADY/WREADY return (with BREADY=1).
- Read: AR handshake at edge N → RVALID=1 and RDATA valid from edge N. With RREADY=1, ARREADY returns edge N+1; one read per 2 cycles.
- Write commit and read capture on the same edge to the same register: read returns pre-write value.
- BREADY/RREADY low: BVALID/RVALID and data held indefinitely; no further AW/W/AR accepted.
- Reset mid-transaction: all FSMs to idle-ready state, pending response dropped, registers to RESET_VAL.

## Configuration
- AXIL_SLV_WSTRB_EN defined: adds input WSTRB [3:0], latched with WDATA; byte k of target register updated only if WSTRB[k]=1. WSTRB=4'b0000 on registers 0–2 → no change, BRESP=OKAY.
- Not defined: no WSTRB port; every write updates all 32 bits.

## Test plan
- Reset: hold ARESETn=0 3 cycles → reg0–2=RESET_VAL, all VALID/READY=0; next edge AWREADY=WREADY=ARREADY=1.
- AW then W two cycles later, addr 4'h4, data 32'hDEAD_BEEF → reg1=DEADBEEF one edge after W handshake, BVALID=1, BRESP=00.
- W before AW, and same-cycle AW+W, addr 4'h8 data 32'h1234_5678 → reg2=12345678, single B response each; BREADY held low 5 cycles → BVALID held, AWREADY=0.
- Write to addr 4'hC → BRESP=2'b10, reg0–2 unchanged; read addr 4'hC with status=32'hA5A5_0001 → RDATA=A5A50001, RRESP=00.
- Concurrent read and write to reg0 (old 0, new 32'h0000_00FF) on same commit edge → RDATA=0; subsequent read → 000000FF. RREADY low 4 cycles → RDATA stable.
- With AXIL_SLV_WSTRB_EN: reg0=32'h1111_1111, write 32'hAABB_CCDD WSTRB=4'b0101 → reg0=32'h11BB_11DD.
